vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator: recovers pixel coordinates and frame timing from an active-low hsync/vsync pair. Runs on the system clock, gated by a one-cycle pixel strobe. Measures line length and lines per frame, declares lock after stable frames, and flags timing faults. It sits between a captured or looped-back sync stream and any consumer needing (x, y) plus a frame-start pulse, such as a frame grabber or a self-check of the display path.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_sync_edge.sv | 23 ++
 rtl/vga_sync_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and lock-state encoding for the VGA sync receive path.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

    localparam int unsigned H_ACTIVE_START_DEF = 145;
    localparam int unsigned H_ACTIVE_DEF       = 640;
    localparam int unsigned V_ACTIVE_START_DEF = 34;
    localparam int unsigned V_ACTIVE_DEF       = 480;
    localparam int unsigned LOCK_FRAMES_DEF    = 2;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Strobe-gated sample register with falling-edge detect for an active-low sync input.
module vga_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_sync,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b1;
        end else if (i_en) begin
            r_prev <= i_sync;
        end
    end

    // Combinational so counters can react on the same strobe that sees the edge.
    assign o_fall = i_en & r_prev & ~i_sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, frame timing and lock status from an active-low hsync/vsync pair.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE_START = H_ACTIVE_START_DEF,
    parameter int unsigned H_ACTIVE       = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE_START = V_ACTIVE_START_DEF,
    parameter int unsigned V_ACTIVE       = V_ACTIVE_DEF,
    parameter int unsigned LOCK_FRAMES    = LOCK_FRAMES_DEF
) (
    input  logic        real100clock,
    input  logic        reset,
    input  logic        pixelEnable,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  xPixel,
    output logic [8:0]  yPixel,
    output logic        pixelValid,
    output logic        frameStart,
    output logic        locked,
    output logic [10:0] lineLength,
    output logic [10:0] frameLines,
    output logic        timingError
);

    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_ACTIVE_START);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_ACTIVE_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_ACTIVE_START);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_ACTIVE_START + V_ACTIVE);

    localparam int unsigned MATCH_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE    = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(LOCK_FRAMES);

    logic w_hFall;
    logic w_vFall;

    vga_sync_edge u_hsync_edge (
        .i_clk  (real100clock),
        .i_rst  (reset),
        .i_en   (pixelEnable),
        .i_sync (hsync),
        .o_fall (w_hFall)
    );

    vga_sync_edge u_vsync_edge (
        .i_clk  (real100clock),
        .i_rst  (reset),
        .i_en   (pixelEnable),
        .i_sync (vsync),
        .o_fall (w_vFall)
    );

    lock_state_t        r_state;
    lock_state_t        w_stateNext;
    logic [CNT_W-1:0]   r_hCount;
    logic [CNT_W-1:0]   r_vCount;
    logic [CNT_W-1:0]   r_refLine;
    logic [CNT_W-1:0]   r_refFrame;
    logic               r_vArmed;
    logic [MATCH_W-1:0] r_matchCnt;

    logic [CNT_W-1:0]   w_hNext;
    logic [CNT_W-1:0]   w_vNext;
    logic [CNT_W-1:0]   w_lineMeas;
    logic [CNT_W-1:0]   w_frameMeas;
    logic [CNT_W-1:0]   w_refLineNext;
    logic [CNT_W-1:0]   w_refFrameNext;
    logic [MATCH_W-1:0] w_matchNext;
    logic [MATCH_W-1:0] w_matchInc;
    logic               w_armNext;
    logic               w_frameEvt;
    logic               w_hTimeout;
    logic               w_vTimeout;
    logic               w_fault;
    logic               w_inWindow;
    logic               w_validNext;

    always_comb begin
        w_lineMeas  = r_hCount + 1'b1;
        w_frameMeas = r_vCount + 1'b1;
        // A vsync edge on the same strobe as the hsync edge is consumed at once.
        w_frameEvt  = w_hFall & (r_vArmed | w_vFall);
        w_hTimeout  = pixelEnable & ~w_hFall & (r_hCount == CNT_PRE);
        w_vTimeout  = w_hFall & ~w_frameEvt & (r_vCount == CNT_PRE);

        w_hNext = r_hCount;
        if (w_hFall) begin
            w_hNext = '0;
        end else if (pixelEnable && (r_hCount != CNT_MAX)) begin
            w_hNext = r_hCount + 1'b1;
        end

        w_vNext = r_vCount;
        if (w_frameEvt) begin
            w_vNext = '0;
        end else if (w_hFall && (r_vCount != CNT_MAX)) begin
            w_vNext = r_vCount + 1'b1;
        end

        w_armNext = r_vArmed;
        if (w_frameEvt) begin
            w_armNext = 1'b0;
        end else if (w_vFall) begin
            w_armNext = 1'b1;
        end
    end

    assign w_matchInc = r_matchCnt + 1'b1;

    always_comb begin
        w_stateNext    = r_state;
        w_matchNext    = r_matchCnt;
        w_refLineNext  = r_refLine;
        w_refFrameNext = r_refFrame;
        w_fault        = 1'b0;

        case (r_state)
            SEARCH: begin
                if (w_frameEvt) begin
                    w_stateNext    = VERIFY;
                    w_matchNext    = MATCH_ONE;
                    w_refLineNext  = w_lineMeas;
                    w_refFrameNext = w_frameMeas;
                end
            end
            VERIFY: begin
                // The count is of consecutive agreeing frames, so a new run starts at one.
                if (w_frameEvt) begin
                    if ((w_lineMeas == r_refLine) && (w_frameMeas == r_refFrame)) begin
                        if (w_matchInc == MATCH_TARGET) begin
                            w_stateNext = LOCKED;
                        end
                        w_matchNext = w_matchInc;
                    end else begin
                        w_matchNext    = MATCH_ONE;
                        w_refLineNext  = w_lineMeas;
                        w_refFrameNext = w_frameMeas;
                    end
                end
            end
            LOCKED: begin
                if ((w_hFall && (w_lineMeas != r_refLine)) ||
                    (w_frameEvt && (w_frameMeas != r_refFrame))) begin
                    w_fault     = 1'b1;
                    w_stateNext = SEARCH;
                end
            end
            default: begin
                w_stateNext = SEARCH;
            end
        endcase

        if (w_hTimeout || w_vTimeout) begin
            w_fault     = 1'b1;
            w_stateNext = SEARCH;
        end
    end

    always_comb begin
        w_inWindow  = (w_hNext >= H_LO) && (w_hNext < H_HI) &&
                      (w_vNext >= V_LO) && (w_vNext < V_HI);
        w_validNext = (w_stateNext == LOCKED) && w_inWindow;
    end

    always_ff @(posedge real100clock or posedge reset) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_hCount    <= '0;
            r_vCount    <= '0;
            r_refLine   <= '0;
            r_refFrame  <= '0;
            r_vArmed    <= 1'b0;
            r_matchCnt  <= '0;
            xPixel      <= '0;
            yPixel      <= '0;
            pixelValid  <= 1'b0;
            frameStart  <= 1'b0;
            locked      <= 1'b0;
            lineLength  <= '0;
            frameLines  <= '0;
            timingError <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_hCount    <= w_hNext;
            r_vCount    <= w_vNext;
            r_refLine   <= w_refLineNext;
            r_refFrame  <= w_refFrameNext;
            r_vArmed    <= w_armNext;
            r_matchCnt  <= w_matchNext;
            frameStart  <= w_frameEvt;
            timingError <= w_fault;
            locked      <= (w_stateNext == LOCKED);
            pixelValid  <= w_validNext;
            if (w_hFall) begin
                lineLength <= w_lineMeas;
            end
            if (w_frameEvt) begin
                frameLines <= w_frameMeas;
            end
            if (w_validNext) begin
                xPixel <= 10'(w_hNext - H_LO);
                yPixel <= 9'(w_vNext - V_LO);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled sync stream (40-pixel lines, 12-line frames).
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    logic        real100clock;
    logic        reset;
    logic        pixelEnable;
    logic        hsync;
    logic        vsync;
    logic [9:0]  xPixel;
    logic [8:0]  yPixel;
    logic        pixelValid;
    logic        frameStart;
    logic        locked;
    logic [10:0] lineLength;
    logic [10:0] frameLines;
    logic        timingError;

    int n_checks = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;
    int te_cnt   = 0;
    int line_idx = 0;
    int vfall_at = 0;
    logic cap_fs;
    logic cap_te;

    vga_sync_decoder #(
        .H_ACTIVE_START (10),
        .H_ACTIVE       (24),
        .V_ACTIVE_START (4),
        .V_ACTIVE       (6),
        .LOCK_FRAMES    (2)
    ) dut (
        .real100clock (real100clock),
        .reset        (reset),
        .pixelEnable  (pixelEnable),
        .hsync        (hsync),
        .vsync        (vsync),
        .xPixel       (xPixel),
        .yPixel       (yPixel),
        .pixelValid   (pixelValid),
        .frameStart   (frameStart),
        .locked       (locked),
        .lineLength   (lineLength),
        .frameLines   (frameLines),
        .timingError  (timingError)
    );

    initial real100clock = 1'b0;
    always #5 real100clock = ~real100clock;

    always @(negedge real100clock) begin
        if (frameStart)  fs_cnt++;
        if (timingError) te_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, " xPixel"},      32'(xPixel),      0);
        check_val({pfx, " yPixel"},      32'(yPixel),      0);
        check_val({pfx, " pixelValid"},  32'(pixelValid),  0);
        check_val({pfx, " frameStart"},  32'(frameStart),  0);
        check_val({pfx, " locked"},      32'(locked),      0);
        check_val({pfx, " lineLength"},  32'(lineLength),  0);
        check_val({pfx, " frameLines"},  32'(frameLines),  0);
        check_val({pfx, " timingError"}, 32'(timingError), 0);
    endtask

    // hsync low for pixels 2..5 of each line; vsync low for lines 8..9.
    function automatic logic hs_of(input int p);
        return (p >= 2 && p < 6) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic vs_of(input int l, input int p);
        if (l == 8) return (p >= vfall_at) ? 1'b0 : 1'b1;
        if (l == 9) return 1'b0;
        return 1'b1;
    endfunction

    // Entered and left at posedge+1: one strobe clock then one idle clock.
    task automatic pix(input logic h, input logic v);
        hsync = h;
        vsync = v;
        pixelEnable = 1'b1;
        @(posedge real100clock);
        #1;
        cap_fs = frameStart;
        cap_te = timingError;
        pixelEnable = 1'b0;
        @(posedge real100clock);
        #1;
    endtask

    task automatic do_pixels(input int from, input int to);
        for (int p = from; p <= to; p++) pix(hs_of(p), vs_of(line_idx, p));
    endtask

    task automatic next_line();
        line_idx = (line_idx + 1) % 12;
    endtask

    task automatic do_line(input int len);
        do_pixels(0, len - 1);
        next_line();
    endtask

    task automatic run_lines(input int n);
        for (int i = 0; i < n; i++) do_line(40);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        pixelEnable = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) @(posedge real100clock);
        #1;
        check_zero("rst");
        reset = 1'b0;
        @(posedge real100clock);
        #1;

        // Acquisition: first frame is partial, lock at the third frameStart.
        run_lines(8);
        check_val("fs0 count", 32'(fs_cnt), 0);
        check_val("acq lineLength", 32'(lineLength), 40);
        do_line(40);
        check_val("fs1 count", 32'(fs_cnt), 1);
        check_val("fs1 frameLines", 32'(frameLines), 9);
        check_val("fs1 locked", 32'(locked), 0);
        run_lines(12);
        check_val("fs2 count", 32'(fs_cnt), 2);
        check_val("fs2 frameLines", 32'(frameLines), 12);
        check_val("fs2 locked", 32'(locked), 0);
        run_lines(11);
        check_val("pre fs3 locked", 32'(locked), 0);
        do_line(40);
        check_val("fs3 count", 32'(fs_cnt), 3);
        check_val("fs3 locked", 32'(locked), 1);

        // Active window boundaries.
        run_lines(3);
        do_pixels(0, 11);
        check_val("h before window valid", 32'(pixelValid), 0);
        do_pixels(12, 12);
        check_val("first px x", 32'(xPixel), 0);
        check_val("first px y", 32'(yPixel), 0);
        check_val("first px valid", 32'(pixelValid), 1);
        do_pixels(13, 35);
        check_val("last px x", 32'(xPixel), 23);
        check_val("last px valid", 32'(pixelValid), 1);
        do_pixels(36, 36);
        check_val("past h valid", 32'(pixelValid), 0);
        check_val("past h x hold", 32'(xPixel), 23);
        do_pixels(37, 39);
        next_line();
        run_lines(5);
        check_val("last row y", 32'(yPixel), 5);
        do_pixels(0, 12);
        check_val("past v valid", 32'(pixelValid), 0);
        check_val("past v y hold", 32'(yPixel), 5);
        check_val("past v x hold", 32'(xPixel), 23);
        do_pixels(13, 39);
        next_line();
        run_lines(2);
        check_val("fs4 count", 32'(fs_cnt), 4);
        check_val("fs4 locked", 32'(locked), 1);
        check_val("no err yet", 32'(te_cnt), 0);

        // Shortened line while locked.
        run_lines(5);
        do_line(30);
        do_pixels(0, 2);
        check_val("short err pulse", 32'(cap_te), 1);
        check_val("short err count", 32'(te_cnt), 1);
        check_val("short locked", 32'(locked), 0);
        check_val("short lineLength", 32'(lineLength), 30);
        do_pixels(3, 39);
        next_line();
        run_lines(5);
        check_val("relock1 locked", 32'(locked), 0);
        run_lines(12);
        check_val("relock2 locked", 32'(locked), 1);
        check_val("relock err count", 32'(te_cnt), 1);

        // vsync and hsync edges on the same strobe.
        run_lines(11);
        vfall_at = 2;
        do_pixels(0, 2);
        check_val("same fs pulse", 32'(cap_fs), 1);
        check_val("same fs count", 32'(fs_cnt), 7);
        check_val("same frameLines", 32'(frameLines), 12);
        check_val("same locked", 32'(locked), 1);
        do_pixels(3, 39);
        next_line();
        vfall_at = 0;
        run_lines(12);
        check_val("after same frameLines", 32'(frameLines), 12);
        check_val("after same locked", 32'(locked), 1);
        check_val("after same fs count", 32'(fs_cnt), 8);

        // Asynchronous reset mid-line while locked.
        run_lines(4);
        do_pixels(0, 15);
        check_val("pre rst x", 32'(xPixel), 3);
        check_val("pre rst y", 32'(yPixel), 1);
        check_val("pre rst valid", 32'(pixelValid), 1);
        reset = 1'b1;
        #2;
        check_zero("midrst");
        @(posedge real100clock);
        #1;
        reset = 1'b0;
        do_pixels(16, 39);
        next_line();
        run_lines(7);
        check_val("rst fs1 frameLines", 32'(frameLines), 7);
        check_val("rst fs1 locked", 32'(locked), 0);
        run_lines(12);
        check_val("rst fs2 locked", 32'(locked), 0);
        run_lines(12);
        check_val("rst fs3 count", 32'(fs_cnt), 11);
        check_val("rst fs3 locked", 32'(locked), 1);
        check_val("rst no err", 32'(te_cnt), 1);

        // pixelEnable idle for 100 clocks with sync lines wiggled.
        run_lines(5);
        do_pixels(0, 20);
        check_val("pre freeze x", 32'(xPixel), 8);
        check_val("pre freeze y", 32'(yPixel), 2);
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (100) @(posedge real100clock);
        #1;
        check_val("freeze x", 32'(xPixel), 8);
        check_val("freeze y", 32'(yPixel), 2);
        check_val("freeze valid", 32'(pixelValid), 1);
        check_val("freeze locked", 32'(locked), 1);
        check_val("freeze lineLength", 32'(lineLength), 40);
        check_val("freeze fs count", 32'(fs_cnt), 11);
        check_val("freeze err count", 32'(te_cnt), 1);
        do_pixels(21, 39);
        next_line();
        do_pixels(0, 12);
        check_val("post freeze x", 32'(xPixel), 0);
        check_val("post freeze y", 32'(yPixel), 3);
        check_val("post freeze lineLength", 32'(lineLength), 40);
        do_pixels(13, 39);
        next_line();

        // hsync held high: horizontal timeout.
        do_pixels(0, 5);
        for (int i = 0; i < 2100; i++) pix(1'b1, 1'b1);
        check_val("timeout err count", 32'(te_cnt), 2);
        check_val("timeout locked", 32'(locked), 0);
        check_val("timeout valid", 32'(pixelValid), 0);
        check_val("timeout lineLength", 32'(lineLength), 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
